// File: rtl/uart_rx_os.sv
// 16x-oversampled 8N1 UART receiver; rx passes a 2-FF synchroniser, byte strobes one clk after the stop sample.
// Latency: 2 clk sync plus one registered stage. Never stalls: a byte the consumer cannot take is lost downstream.
module uart_rx_os #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 163,
    parameter int DVSR_W  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            busy
);

    localparam int S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    logic              rx_meta_q, rxs_q;
    logic [DVSR_W-1:0] div_q, div_d;
    logic              s_tick;
    state_t            state_q, state_d;
    logic [S_W-1:0]    s_q, s_d;
    logic [N_W-1:0]    n_q, n_d;
    logic [DBIT-1:0]   b_q, b_d;
    logic [DBIT-1:0]   dout_q, dout_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;

    // Synchroniser resets to the idle line level so reset release never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    assign s_tick = (div_q == DVSR_W'(DVSR - 1));

    always_comb begin
        div_d = s_tick ? '0 : div_q + DVSR_W'(1);
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_W'(7)) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = rxs_q ? IDLE : DATA;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_W'(15)) begin
                        s_d = '0;
                        b_d = {rxs_q, b_q[DBIT-1:1]};
                        if (n_q == N_W'(DBIT - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + N_W'(1);
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_W'(SB_TICK - 1)) begin
                        if (rxs_q) begin
                            dout_d  = b_q;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            BREAK: begin
                // A held-low line must return high before another start bit is armed.
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: drives 8N1 frames at DVSR=4 and compares against a byte-level model of the link.
module tb_uart_rx_os;

    localparam int DVSR    = 4;
    localparam int BIT_CLK = 16 * DVSR;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx_os #(.DBIT(8), .SB_TICK(16), .DVSR(DVSR), .DVSR_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Observation side: everything the DUT emits, plus a depth-16 write-only FIFO fed by it.
    logic [7:0] got_q[$];
    logic [7:0] fifo_q[$];
    int         done_cnt = 0;
    int         ferr_cnt = 0;
    int         both_cnt = 0;
    int         busy_bad = 0;
    int         drop_cnt = 0;
    logic       fifo_en  = 1'b0;

    always @(negedge clk) begin
        if (rx_done_tick) begin
            done_cnt++;
            got_q.push_back(dout);
            if (busy) busy_bad++;
            if (fifo_en) begin
                if (fifo_q.size() < 16) fifo_q.push_back(dout);
                else drop_cnt++;
            end
        end
        if (frame_err) ferr_cnt++;
        if (rx_done_tick && frame_err) both_cnt++;
    end

    // Reference model: what a receiver of the link should report.
    logic [7:0] exp_q[$];
    int         exp_ferr = 0;
    logic [7:0] ref_dout = 8'h00;
    int         chk_idx  = 0;

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        drive_bit(stop_ok);
        if (stop_ok) begin
            exp_q.push_back(data);
            ref_dout = data;
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = chk_idx; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), {24'h0, got_q[i]}, {24'h0, exp_q[i]});
        chk_idx = exp_q.size();
        check({tag, "_dout"}, {24'h0, dout}, {24'h0, ref_dout});
        check({tag, "_ferr_cnt"}, ferr_cnt, exp_ferr);
        check({tag, "_both_pulses"}, both_cnt, 0);
        check({tag, "_busy_at_done"}, busy_bad, 0);
    endtask

    initial begin
        int d0;
        int f0;
        reset = 1'b1;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_dout", {24'h0, dout}, 32'h0);
        check("rst_done", {31'h0, rx_done_tick}, 32'h0);
        check("rst_ferr", {31'h0, frame_err}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;
        idle(200);
        check("idle_busy", {31'h0, busy}, 32'h0);

        // Single byte
        send_frame(8'hA5, 1'b1);
        check("a5_pulses", done_cnt, 1);
        check("a5_busy_after", {31'h0, busy}, 32'h0);
        check_stream("a5");

        // Back-to-back, no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(BIT_CLK);
        check_stream("b2b");

        // Glitches shorter than half a bit must be ignored
        d0 = done_cnt;
        rx = 1'b0;
        repeat (12) @(negedge clk);
        idle(200);
        check("glitch_busy", {31'h0, busy}, 32'h0);
        for (int k = 0; k < 6; k++) begin
            rx = 1'b0;
            repeat ($urandom_range(1, 24)) @(negedge clk);
            idle($urandom_range(150, 250));
        end
        check("glitch_no_done", done_cnt, d0);
        check_stream("glitch");

        // Framing error followed by a held break
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        repeat (40 * BIT_CLK) @(negedge clk);
        check("break_busy", {31'h0, busy}, 32'h1);
        check("break_one_ferr", ferr_cnt - f0, 1);
        check("break_no_done", done_cnt, d0);
        idle(BIT_CLK);
        check("break_exit_busy", {31'h0, busy}, 32'h0);
        send_frame(8'h12, 1'b1);
        idle(BIT_CLK);
        check_stream("break");

        // Asynchronous reset in the middle of data bit 4 of 0x81
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i == 0);
        rx = 1'b0;
        repeat (BIT_CLK / 2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_dout", {24'h0, dout}, 32'h0);
        check("mid_rst_done", {31'h0, rx_done_tick}, 32'h0);
        check("mid_rst_ferr", {31'h0, frame_err}, 32'h0);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        ref_dout = 8'h00;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(100);
        d0 = done_cnt;
        send_frame(8'h7E, 1'b1);
        idle(BIT_CLK);
        check("post_rst_pulses", done_cnt - d0, 1);
        check_stream("post_rst");

        // Random frames, random gaps and phases, occasional bad stop bits
        for (int k = 0; k < 30; k++) begin
            logic [7:0] b;
            logic       ok;
            b  = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            send_frame(b, ok);
            if (ok) idle($urandom_range(0, 80));
            else    idle(BIT_CLK + $urandom_range(0, 80));
        end
        idle(BIT_CLK);
        check_stream("rand");

        // Write-only FIFO of depth 16 fed with 17 bytes
        fifo_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1);
            if (i == 15) check("fifo_full_at_16", fifo_q.size(), 16);
        end
        idle(BIT_CLK);
        check("fifo_drop", drop_cnt, 1);
        check("fifo_size", fifo_q.size(), 16);
        for (int i = 0; i < 16 && i < fifo_q.size(); i++)
            check($sformatf("fifo_rd%0d", i), {24'h0, fifo_q[i]}, i);
        check_stream("fifo");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- UART receive front-end for the serial link.
- Oversamples the asynchronous `rx` line at 16x the baud rate and deserialises 8N1 frames, LSB first.
- Presents each received byte on `dout` with a one-cycle `rx_done_tick`.
- Sits directly upstream of the RX byte FIFO: `rx_done_tick` drives the FIFO write strobe and `dout` drives the FIFO write data.

Parameters:
- DBIT, 8, data bits per frame.
- SB_TICK, 16, oversample ticks in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- DVSR, 163, `clk` cycles per oversample tick (50 MHz / (16 × 19200) ≈ 163).
- DVSR_W, 8, width of the tick divider counter; DVSR ≤ 2^DVSR_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  serial input; idle high; asynchronous to `clk`.
- dout  out  DBIT  last received byte; held until the next valid frame.
- rx_done_tick  out  1  one-cycle pulse when `dout` is updated with a valid frame.
- frame_err  out  1  one-cycle pulse when the stop-bit sample is 0.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, active-high) clears:
  - `dout`=0, `rx_done_tick`=0, `frame_err`=0, `busy`=0;
  - state=IDLE, tick divider=0, tick count s=0, bit count n=0, shift register=0;
  - both synchroniser stages=1.
- Reset asserted mid-frame aborts the frame; no pulse is emitted for it.
- Synchroniser:
  - `rx` passes through a 2-FF synchroniser; all decisions use the synchronised `rxs`.
  - Adds 2 `clk` of latency.
- Tick generator:
  - Free-running counter 0..DVSR-1 from reset.
  - `s_tick` is high for one `clk` when the counter equals DVSR-1, then the counter wraps to 0.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when `rxs`=0, go to START with s=0.
  - START:
    - Count ticks.
    - At s=7 (mid start bit): if `rxs`=0, go to DATA with s=0, n=0.
    - If `rxs`=1 at s=7: glitch; return to IDLE with no output.
  - DATA:
    - At s=15: shift `rxs` into the MSB of the shift register (right shift; LSB arrives first) and set s=0.
    - If n=DBIT-1, go to STOP; else n=n+1.
  - STOP:
    - At s=SB_TICK-1, sample `rxs`.
    - If 1: load `dout` from the shift register, pulse `rx_done_tick`, go to IDLE.
    - If 0: pulse `frame_err`, leave `dout` unchanged, go to BREAK.
  - BREAK: wait until `rxs`=1, then go to IDLE. Prevents a held-low line from producing repeated frames.
- Pulse timing:
  - `rx_done_tick` and `frame_err` are registered.
  - They are high for exactly one `clk`, on the cycle after the stop-sample tick.
  - They are never high together.
- Back-to-back frames: a start bit beginning immediately after the stop sample is accepted, since IDLE re-arms on the next cycle.
- Sample phase: because the divider is free-running, sample-point jitter is at most one tick (DVSR `clk`). The bench must allow for this.
- No flow control: if the downstream FIFO is full, the byte is lost at the FIFO. This block does not stall.

Test Plan:
- Single byte: DVSR=4 (bit = 64 clk); send 0xA5 8N1 (start, 1,0,1,0,0,1,0,1, stop) -> exactly one `rx_done_tick`, `dout`=0xA5, `frame_err`=0, `busy` falls within 2 ticks after the stop sample.
- Back-to-back: 0x00, 0xFF, 0x3C with no idle gap -> three `rx_done_tick` pulses, `dout` sequence 0x00, 0xFF, 0x3C, no `frame_err`.
- Glitch rejection: `rx` low for 3 ticks (12 clk), then high -> FSM returns to IDLE, no `rx_done_tick`, no `frame_err`, `dout` unchanged.
- Framing error / break: send 0x55 with stop bit = 0, then hold `rx` low for 40 bit times -> one `frame_err` pulse, no `rx_done_tick`, `busy` stays high (BREAK) until `rx` goes high. Then send 0x12 -> `dout`=0x12.
- Reset mid-frame: assert `reset` during data bit 4 of 0x81 -> all outputs 0 immediately (async). Release, send 0x7E -> `dout`=0x7E, exactly one pulse.
- FIFO integration: connect `rx_done_tick`/`dout` to the FIFO write side (depth 16); send 17 bytes 0x00..0x10 with no reads -> FIFO `full`=1 after the 16th byte, read-out yields 0x00..0x0F, 0x10 is dropped.
